// File: rtl/wb_pkg.sv
// wb_pkg: definitions shared by the two-master Wishbone arbiter.
//   state_t   : arbiter FSM encoding (idle, master 0 owns, master 1 owns)
//   GNT_*     : one-hot grant patterns, bit0 = master 0
//   WB_AW/DW  : default address / data widths
//   gnt_of()  : state -> one-hot grant decode
package wb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

  localparam int WB_AW = 32;
  localparam int WB_DW = 32;

  function automatic logic [1:0] gnt_of(input state_t s);
    logic [1:0] g;
    g = GNT_NONE;
    case (s)
      ST_OWN0: g = GNT_M0;
      ST_OWN1: g = GNT_M1;
      default: g = GNT_NONE;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// wb_timeout_counter: bus-stall watchdog for the arbiter.
//   clk    : system clock, rising edge
//   reset  : asynchronous, active-low
//   en     : a strobe is outstanding this cycle with no acknowledge
//   clr    : the owning master is releasing the bus this cycle
//   expire : combinational; high in the cycle the count reaches TIMEOUT-1
//            while still enabled. TIMEOUT=0 removes the watchdog.
// TIMEOUT must be below 2**TW so the count never wraps.
module wb_timeout_counter
  import wb_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expire
);

  generate
    if (TIMEOUT > 0) begin : g_wd
      localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT - 1);
      logic [TW-1:0] r_cnt;

      assign expire = en && (r_cnt == LIMIT);

      // Any cycle without a pending stalled strobe restarts the count, and
      // an expiry restarts it too so a re-granted master gets a full window.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_cnt <= '0;
        end else if (clr || !en || expire) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end else begin : g_no_wd
      assign expire = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master, one-slave Wishbone classic arbiter.
//   clk, reset         : clock (rising edge), asynchronous active-low reset
//   m0_* / m1_*        : master ports (adr, dat_w, we, sel, stb, cyc in;
//                        dat_r, ack, err out)
//   s_*                : slave (RAM) port (adr, dat_w, we, sel, stb, cyc out;
//                        dat_r, ack in)
//   gnt                : one-hot current grant, bit0 = master 0
// Round-robin arbitration; the grant is locked for the whole CYC and a
// stalled strobe is aborted with a one-cycle err pulse after TIMEOUT cycles.
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int AW      = WB_AW,
  parameter int DW      = WB_DW,
  parameter int TIMEOUT = 255,
  parameter int TW      = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   m0_adr,
  input  logic [DW-1:0]   m0_dat_w,
  output logic [DW-1:0]   m0_dat_r,
  input  logic            m0_we,
  input  logic [DW/8-1:0] m0_sel,
  input  logic            m0_stb,
  input  logic            m0_cyc,
  output logic            m0_ack,
  output logic            m0_err,
  input  logic [AW-1:0]   m1_adr,
  input  logic [DW-1:0]   m1_dat_w,
  output logic [DW-1:0]   m1_dat_r,
  input  logic            m1_we,
  input  logic [DW/8-1:0] m1_sel,
  input  logic            m1_stb,
  input  logic            m1_cyc,
  output logic            m1_ack,
  output logic            m1_err,
  output logic [AW-1:0]   s_adr,
  output logic [DW-1:0]   s_dat_w,
  input  logic [DW-1:0]   s_dat_r,
  output logic            s_we,
  output logic [DW/8-1:0] s_sel,
  output logic            s_stb,
  output logic            s_cyc,
  input  logic            s_ack,
  output logic [1:0]      gnt
);

  state_t     r_state;
  logic       r_last;   // index of the master that most recently held the bus
  logic [1:0] r_err;
  logic       w_own0;
  logic       w_own1;
  logic       w_wd_en;
  logic       w_wd_clr;
  logic       w_expire;

  assign w_own0 = (r_state == ST_OWN0);
  assign w_own1 = (r_state == ST_OWN1);
  assign gnt    = gnt_of(r_state);

  // Slave-side mux. Strobe is qualified by cyc so the release cycle
  // never presents a stray strobe to the RAM.
  always_comb begin
    s_adr   = '0;
    s_dat_w = '0;
    s_we    = 1'b0;
    s_sel   = '0;
    s_stb   = 1'b0;
    s_cyc   = 1'b0;
    if (w_own0) begin
      s_adr   = m0_adr;
      s_dat_w = m0_dat_w;
      s_we    = m0_we;
      s_sel   = m0_sel;
      s_stb   = m0_stb & m0_cyc;
      s_cyc   = m0_cyc;
    end else if (w_own1) begin
      s_adr   = m1_adr;
      s_dat_w = m1_dat_w;
      s_we    = m1_we;
      s_sel   = m1_sel;
      s_stb   = m1_stb & m1_cyc;
      s_cyc   = m1_cyc;
    end
  end

  // An ack seen while idle reaches nobody.
  assign m0_ack   = w_own0 & s_ack;
  assign m1_ack   = w_own1 & s_ack;
  assign m0_err   = r_err[0];
  assign m1_err   = r_err[1];
  assign m0_dat_r = s_dat_r;
  assign m1_dat_r = s_dat_r;

  // Ack in the expiry cycle masks en, so the ack wins over the timeout.
  assign w_wd_en  = (w_own0 | w_own1) & s_stb & ~s_ack;
  assign w_wd_clr = (w_own0 & ~m0_cyc) | (w_own1 & ~m1_cyc);

  wb_timeout_counter #(
    .TIMEOUT (TIMEOUT),
    .TW      (TW)
  ) u_wd (
    .clk    (clk),
    .reset  (reset),
    .en     (w_wd_en),
    .clr    (w_wd_clr),
    .expire (w_expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_err   <= GNT_NONE;
    end else begin
      r_err <= GNT_NONE;
      case (r_state)
        ST_IDLE: begin
          // On a tie the master that did not go last wins.
          if (m0_cyc && m1_cyc) begin
            r_state <= r_last ? ST_OWN0 : ST_OWN1;
          end else if (m0_cyc) begin
            r_state <= ST_OWN0;
          end else if (m1_cyc) begin
            r_state <= ST_OWN1;
          end
        end
        ST_OWN0: begin
          if (w_expire) begin
            r_err   <= GNT_M0;
            r_state <= ST_IDLE;
            r_last  <= 1'b0;
          end else if (!m0_cyc) begin
            r_last  <= 1'b0;
            r_state <= m1_cyc ? ST_OWN1 : ST_IDLE;
          end
        end
        ST_OWN1: begin
          if (w_expire) begin
            r_err   <= GNT_M1;
            r_state <= ST_IDLE;
            r_last  <= 1'b1;
          end else if (!m1_cyc) begin
            r_last  <= 1'b1;
            r_state <= m0_cyc ? ST_OWN0 : ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: directed bench for wb_arbiter2 with a small RAM model.
// Stimulus pushes the expected response of every access into a queue; a
// monitor pops one entry for each ack/err the DUT presents and compares.
module tb_wb_arbiter2;

  typedef struct {
    int          src;
    bit          is_err;
    bit          chk_data;
    logic [31:0] data;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] m_adr   [2];
  logic [31:0] m_dat_w [2];
  logic        m_we    [2];
  logic [3:0]  m_sel   [2];
  logic        m_stb   [2];
  logic        m_cyc   [2];
  logic [31:0] m0_dat_r, m1_dat_r;
  logic        m0_ack, m0_err, m1_ack, m1_err;
  logic [31:0] s_adr, s_dat_w;
  logic        s_we, s_stb, s_cyc;
  logic [3:0]  s_sel;
  logic [1:0]  gnt;

  // RAM model: acks ram_wait+1 cycles after it first sees a strobe.
  logic [31:0] mem [0:63];
  logic        ram_ack   = 1'b0;
  logic [31:0] ram_rdata = 32'h0;
  int          ram_wait  = 0;
  int          ram_wcnt  = 0;

  always #5 clk = ~clk;

  wb_arbiter2 #(.AW(32), .DW(32), .TIMEOUT(8), .TW(8)) dut (
    .clk      (clk),
    .reset    (rst_n),
    .m0_adr   (m_adr[0]),
    .m0_dat_w (m_dat_w[0]),
    .m0_dat_r (m0_dat_r),
    .m0_we    (m_we[0]),
    .m0_sel   (m_sel[0]),
    .m0_stb   (m_stb[0]),
    .m0_cyc   (m_cyc[0]),
    .m0_ack   (m0_ack),
    .m0_err   (m0_err),
    .m1_adr   (m_adr[1]),
    .m1_dat_w (m_dat_w[1]),
    .m1_dat_r (m1_dat_r),
    .m1_we    (m_we[1]),
    .m1_sel   (m_sel[1]),
    .m1_stb   (m_stb[1]),
    .m1_cyc   (m_cyc[1]),
    .m1_ack   (m1_ack),
    .m1_err   (m1_err),
    .s_adr    (s_adr),
    .s_dat_w  (s_dat_w),
    .s_dat_r  (ram_rdata),
    .s_we     (s_we),
    .s_sel    (s_sel),
    .s_stb    (s_stb),
    .s_cyc    (s_cyc),
    .s_ack    (ram_ack),
    .gnt      (gnt)
  );

  always @(posedge clk) begin
    ram_ack <= 1'b0;
    if (s_cyc && s_stb && !ram_ack) begin
      if (ram_wcnt >= ram_wait) begin
        ram_ack  <= 1'b1;
        ram_wcnt <= 0;
        if (s_we) begin
          for (int b = 0; b < 4; b++)
            if (s_sel[b]) mem[s_adr[7:2]][8*b +: 8] <= s_dat_w[8*b +: 8];
        end
        ram_rdata <= mem[s_adr[7:2]];
      end else begin
        ram_wcnt <= ram_wcnt + 1;
      end
    end else if (!s_stb) begin
      ram_wcnt <= 0;
    end
  end

  // Monitor: every ack/err must match the oldest expected response.
  logic [1:0]  mon_ack, mon_err;
  logic [31:0] mon_dat [2];
  assign mon_ack    = {m1_ack, m0_ack};
  assign mon_err    = {m1_err, m0_err};
  assign mon_dat[0] = m0_dat_r;
  assign mon_dat[1] = m1_dat_r;

  always @(negedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (mon_ack[m] || mon_err[m]) begin
        checks++;
        if (sb_q.size() == 0) begin
          failures++;
          $display("FAIL sb_unexpected m%0d: got ack=%0b err=%0b, want no response",
                   m, mon_ack[m], mon_err[m]);
        end else begin
          mon_e = sb_q.pop_front();
          if (mon_e.src != m || mon_ack[m] == mon_err[m] || mon_err[m] != mon_e.is_err ||
              (mon_e.chk_data && mon_dat[m] !== mon_e.data)) begin
            failures++;
            $display("FAIL sb_resp: got m%0d ack=%0b err=%0b data=%08h, want m%0d err=%0b data=%08h",
                     m, mon_ack[m], mon_err[m], mon_dat[m], mon_e.src, mon_e.is_err, mon_e.data);
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input int m, input bit is_err, input bit chk_data, input logic [31:0] d);
    sb_q.push_back('{src: m, is_err: is_err, chk_data: chk_data, data: d});
  endtask

  task automatic req(input int m, input bit we, input logic [31:0] adr,
                     input logic [31:0] dat, input logic [3:0] sel);
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we;
    m_adr[m] = adr;  m_dat_w[m] = dat; m_sel[m] = sel;
  endtask

  task automatic drop(input int m);
    @(posedge clk); #1;
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_we[m] = 1'b0;
  endtask

  // n = negedge index (0 = first negedge after the call) where ack/err appeared.
  task automatic wait_resp(input int m, input string name, output int n);
    n = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((m == 0 && (m0_ack || m0_err)) || (m == 1 && (m1_ack || m1_err))) begin
        n = i;
        break;
      end
    end
    if (n < 0) begin
      checks++;
      failures++;
      $display("FAIL %s_wait: actual=no response from m%0d in 40 cycles expected=response", name, m);
    end
  endtask

  task automatic single(input int m, input bit we, input logic [31:0] adr, input logic [31:0] dat,
                        input logic [3:0] sel, input bit chk_data, input logic [31:0] ed,
                        input string name);
    int n;
    @(posedge clk); #1;
    req(m, we, adr, dat, sel);
    push(m, 1'b0, chk_data, ed);
    wait_resp(m, name, n);
    drop(m);
  endtask

  initial begin
    int n;
    for (int m = 0; m < 2; m++) begin
      m_adr[m] = '0; m_dat_w[m] = '0; m_we[m] = 1'b0;
      m_sel[m] = '0; m_stb[m] = 1'b0; m_cyc[m] = 1'b0;
    end

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_s_cyc_stb", {s_cyc, s_stb}, 2'b00);
    chk("rst_ack_err", {m0_ack, m0_err, m1_ack, m1_err}, 4'b0000);
    @(posedge clk); #1; rst_n = 1'b1;

    // m0 single write, then read back
    @(posedge clk); #1;
    req(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
    push(0, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    chk("t1_gnt_before", gnt, 2'b00);
    @(negedge clk);
    chk("t1_gnt_after", gnt, 2'b01);
    chk("t1_s_adr", s_adr, 32'h10);
    chk("t1_s_we_cyc_stb", {s_we, s_cyc, s_stb}, 3'b111);
    chk("t1_s_dat_w", s_dat_w, 32'hDEADBEEF);
    wait_resp(0, "t1", n);
    chk("t1_ack_latency", n, 0);
    drop(0);
    single(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b1, 32'hDEADBEEF, "t1_rd");

    // Tie from reset: m0 first, direct handoff to m1, next tie m0 again
    @(posedge clk); #1; rst_n = 1'b0;
    @(posedge clk); #1; rst_n = 1'b1;
    req(0, 1'b1, 32'h20, 32'h11111111, 4'hF);
    req(1, 1'b1, 32'h24, 32'h22222222, 4'hF);
    push(0, 1'b0, 1'b0, 32'h0);
    push(1, 1'b0, 1'b0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    chk("t2_tie_gnt", gnt, 2'b01);
    wait_resp(0, "t2_m0", n);
    drop(0);
    @(negedge clk);
    chk("t2_release_gnt", gnt, 2'b01);
    chk("t2_release_s_cyc", s_cyc, 1'b0);
    @(negedge clk);
    chk("t2_handoff_gnt", gnt, 2'b10);
    wait_resp(1, "t2_m1", n);
    drop(1);
    @(posedge clk); #1;
    req(0, 1'b0, 32'h24, 32'h0, 4'hF);
    req(1, 1'b0, 32'h20, 32'h0, 4'hF);
    push(0, 1'b0, 1'b1, 32'h22222222);
    push(1, 1'b0, 1'b1, 32'h11111111);
    @(negedge clk);
    @(negedge clk);
    chk("t2_tie2_gnt", gnt, 2'b01);
    wait_resp(0, "t2_m0b", n);
    drop(0);
    wait_resp(1, "t2_m1b", n);
    drop(1);

    // Burst lock: four m0 beats while m1 waits
    @(posedge clk); #1;
    req(0, 1'b1, 32'h0, 32'hA0, 4'hF);
    req(1, 1'b0, 32'h0, 32'h0, 4'hF);
    for (int b = 0; b < 4; b++) push(0, 1'b0, 1'b0, 32'h0);
    push(1, 1'b0, 1'b1, 32'hA0);
    for (int b = 0; b < 4; b++) begin
      wait_resp(0, "t3_beat", n);
      chk("t3_m1_ack_locked", {m1_ack, gnt}, 3'b001);
      if (b < 3) begin
        @(posedge clk); #1;
        m_adr[0] = 32'(4 * (b + 1));
        m_dat_w[0] = 32'hA0 + 32'(b + 1);
      end
    end
    drop(0);
    @(negedge clk);
    chk("t3_release_gnt", gnt, 2'b01);
    @(negedge clk);
    chk("t3_handoff_gnt", gnt, 2'b10);
    wait_resp(1, "t3_m1", n);
    drop(1);
    single(1, 1'b0, 32'hC, 32'h0, 4'hF, 1'b1, 32'hA3, "t3_rd_last");

    // Byte selects: only the low half of word 0 is overwritten
    single(0, 1'b1, 32'h0, 32'hFFFFFFFF, 4'b0011, 1'b0, 32'h0, "t3_sel_wr");
    single(1, 1'b0, 32'h0, 32'h0, 4'hF, 1'b1, 32'h0000FFFF, "t3_sel_rd");

    // Timeout: RAM never acks, m1 keeps cyc high through the err
    @(posedge clk); #1;
    ram_wait = 1000;
    req(1, 1'b0, 32'h30, 32'h0, 4'hF);
    push(1, 1'b1, 1'b0, 32'h0);
    wait_resp(1, "t4", n);
    chk("t4_err_cycle", n, 9);
    chk("t4_gnt_idle", gnt, 2'b00);
    chk("t4_m0_err", m0_err, 1'b0);
    drop(1);
    @(negedge clk);
    chk("t4_rearb_gnt", gnt, 2'b10);
    chk("t4_err_one_cycle", m1_err, 1'b0);
    @(negedge clk);
    chk("t4_final_gnt", gnt, 2'b00);

    // Ack arrives in the cycle the watchdog would fire
    @(posedge clk); #1;
    ram_wait = 6;
    req(0, 1'b1, 32'h34, 32'h55, 4'hF);
    push(0, 1'b0, 1'b0, 32'h0);
    wait_resp(0, "t5", n);
    chk("t5_ack_cycle", n, 8);
    chk("t5_ack_not_err", {m0_ack, m0_err}, 2'b10);
    drop(0);
    @(negedge clk);
    chk("t5_no_late_err", m0_err, 1'b0);
    ram_wait = 0;

    // Asynchronous reset while m1 owns the bus and the RAM is acking
    @(posedge clk); #1;
    req(1, 1'b1, 32'h38, 32'h77, 4'hF);
    @(negedge clk);
    @(negedge clk);
    chk("t6_gnt_own1", {gnt, s_stb}, 3'b101);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    chk("t6_async_s_cyc_stb", {s_cyc, s_stb}, 2'b00);
    chk("t6_async_gnt", gnt, 2'b00);
    chk("t6_async_m1_ack", m1_ack, 1'b0);
    chk("t6_async_s_adr", s_adr, 32'h0);
    req(0, 1'b0, 32'h10, 32'h0, 4'hF);
    push(0, 1'b0, 1'b1, 32'hDEADBEEF);
    push(1, 1'b0, 1'b0, 32'h0);
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t6_post_rst_idle", gnt, 2'b00);
    @(negedge clk);
    chk("t6_post_rst_gnt", gnt, 2'b01);
    wait_resp(0, "t6_m0", n);
    drop(0);
    wait_resp(1, "t6_m1", n);
    drop(1);
    single(0, 1'b0, 32'h38, 32'h0, 4'hF, 1'b1, 32'h77, "t6_rd");

    repeat (3) @(negedge clk);
    chk("sb_drained", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: actual=still running expected=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
